// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm sweep checker.
// Imported by the checker top and its testbench.
package minterm_pkg;

    localparam int N_IN = 4;
    localparam int TT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [TT_W-1:0] tt_t;

endpackage

// File: rtl/settle_timer.sv
// 8-bit loadable down-counter with zero flag.
// Paces how long each input code is held.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps a 4-input unit through all codes, captures its truth table
// and compares it against an expected minterm mask.
module minterm_sweep_checker
    import minterm_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  a_out,
    input  logic        d_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] observed,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t state, state_n;
    tt_t    expected_q;
    logic   timer_load;
    logic   timer_en;
    logic   timer_zero;
    logic   sample;
    logic   accept;
    logic   last_code;
    logic   miss;

    settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (RELOAD),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    assign last_code = (a_out == 4'hF);
    assign miss      = d_in ^ expected_q[a_out];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        sample     = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_n    = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    sample = 1'b1;
                    if (last_code) begin
                        state_n = DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // pass is resolved on the final sample edge so it is already
    // valid in the done cycle, including that last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out            <= 4'd0;
            expected_q       <= '0;
            observed         <= '0;
            mismatch_count   <= 5'd0;
            first_fail       <= 4'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (accept) begin
            a_out            <= 4'd0;
            expected_q       <= expected;
            observed         <= '0;
            mismatch_count   <= 5'd0;
            first_fail       <= 4'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (sample) begin
            observed[a_out] <= d_in;
            if (miss) begin
                mismatch_count <= mismatch_count + 5'd1;
                if (!first_fail_valid) begin
                    first_fail       <= a_out;
                    first_fail_valid <= 1'b1;
                end
            end
            if (last_code) begin
                pass <= (mismatch_count == 5'd0) && !miss;
            end else begin
                a_out <= a_out + 4'd1;
            end
        end
    end

    assign busy = (state == SETTLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed self-checking bench for minterm_sweep_checker.
// Two instances: default settle (4) and settle of 3 with a delayed model.
module tb_minterm_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] exp4 = 16'h0;
    logic [3:0]  a4;
    logic        d4;
    logic        busy4, done4, pass4, ffv4;
    logic [15:0] obs4;
    logic [4:0]  mc4;
    logic [3:0]  ff4;

    logic        start3 = 1'b0;
    logic [15:0] exp3 = 16'h0;
    logic [3:0]  a3;
    logic        d3;
    logic        busy3, done3, pass3, ffv3;
    logic [15:0] obs3;
    logic [4:0]  mc3;
    logic [3:0]  ff3;

    logic        stuck = 1'b0;
    logic        use3 = 1'b0;
    logic [3:0]  ad1 = 4'd0, ad2 = 4'd0, ad3 = 4'd0;

    int checks = 0;
    int failures = 0;
    int dcnt4 = 0;
    int dcnt3 = 0;

    always #5 clk = ~clk;

    function automatic logic model(input logic [3:0] a);
        return (a == 4'hA) || (a == 4'h5);
    endfunction

    assign d4 = stuck ? 1'b1 : model(a4);
    assign d3 = model(use3 ? ad3 : ad2);

    always @(posedge clk) begin
        ad1 <= a3;
        ad2 <= ad1;
        ad3 <= ad2;
        if (done4) dcnt4 <= dcnt4 + 1;
        if (done3) dcnt3 <= dcnt3 + 1;
    end

    minterm_sweep_checker dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4),
        .a_out(a4), .d_in(d4), .busy(busy4), .done(done4), .pass(pass4),
        .observed(obs4), .mismatch_count(mc4), .first_fail(ff4),
        .first_fail_valid(ffv4)
    );

    minterm_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
        .a_out(a3), .d_in(d3), .busy(busy3), .done(done3), .pass(pass3),
        .observed(obs3), .mismatch_count(mc3), .first_fail(ff3),
        .first_fail_valid(ffv3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Runs one sweep on dut4; returns the cycle (1 = cycle starting at
    // the accepting edge) in which done was seen, and a_out sequence errors.
    task automatic run4(input logic [15:0] e, input bit glitch,
                        output int done_cyc, output int seq_err);
        done_cyc = 0;
        seq_err  = 0;
        @(negedge clk);
        exp4   = e;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (c <= 64 && a4 !== 4'((c - 1) / 4)) seq_err++;
            if (glitch && c == 10) start4 = 1'b1;
            if (done4) begin
                done_cyc = c;
                if (glitch) start4 = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic run3(input logic [15:0] e, output int done_cyc);
        done_cyc = 0;
        @(negedge clk);
        exp3   = e;
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done3) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int dc;
        int se;
        int d0;

        repeat (3) @(negedge clk);
        chk("rst_a_out", 32'(a4), 32'h0);
        chk("rst_busy", 32'(busy4), 32'h0);
        chk("rst_done", 32'(done4), 32'h0);
        chk("rst_pass", 32'(pass4), 32'h0);
        chk("rst_observed", 32'(obs4), 32'h0);
        chk("rst_mismatch", 32'(mc4), 32'h0);
        chk("rst_first_fail", 32'(ff4), 32'h0);
        chk("rst_ffv", 32'(ffv4), 32'h0);

        rst_n = 1'b1;
        se = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy4 !== 1'b0) se++;
        end
        chk("idle_busy_cycles", 32'(se), 32'h0);

        // Correct unit under test
        run4(16'h0420, 1'b0, dc, se);
        chk("good_done_cycle", 32'(dc), 32'd65);
        chk("good_a_seq", 32'(se), 32'h0);
        chk("good_pass", 32'(pass4), 32'h1);
        chk("good_observed", 32'(obs4), 32'h0420);
        chk("good_mismatch", 32'(mc4), 32'h0);
        chk("good_ffv", 32'(ffv4), 32'h0);
        chk("good_hold_a", 32'(a4), 32'hF);
        chk("good_hold_pass", 32'(pass4), 32'h1);
        chk("good_idle_busy", 32'(busy4), 32'h0);

        // Stuck-at-1 unit under test
        stuck = 1'b1;
        run4(16'h0420, 1'b0, dc, se);
        chk("stuck_done_cycle", 32'(dc), 32'd65);
        chk("stuck_pass", 32'(pass4), 32'h0);
        chk("stuck_observed", 32'(obs4), 32'hFFFF);
        chk("stuck_mismatch", 32'(mc4), 32'd14);
        chk("stuck_first_fail", 32'(ff4), 32'h0);
        chk("stuck_ffv", 32'(ffv4), 32'h1);
        stuck = 1'b0;

        // Settle of 3, unit output lagging 2 cycles: passes
        use3 = 1'b0;
        run3(16'h0420, dc);
        chk("lag2_done_cycle", 32'(dc), 32'd49);
        chk("lag2_pass", 32'(pass3), 32'h1);
        chk("lag2_observed", 32'(obs3), 32'h0420);

        // Lagging 3 cycles: each code sees the previous code's response
        use3 = 1'b1;
        run3(16'h0420, dc);
        chk("lag3_done_cycle", 32'(dc), 32'd49);
        chk("lag3_pass", 32'(pass3), 32'h0);
        chk("lag3_observed", 32'(obs3), 32'h0840);
        chk("lag3_mismatch", 32'(mc3), 32'd4);
        chk("lag3_first_fail", 32'(ff3), 32'd5);
        chk("lag3_ffv", 32'(ffv3), 32'h1);

        // Starts mid-sweep and in the done cycle are ignored
        d0 = dcnt4;
        run4(16'h0420, 1'b1, dc, se);
        repeat (5) @(negedge clk);
        chk("ign_done_cycle", 32'(dc), 32'd65);
        chk("ign_a_seq", 32'(se), 32'h0);
        chk("ign_done_count", 32'(dcnt4 - d0), 32'd1);
        chk("ign_busy_after", 32'(busy4), 32'h0);
        chk("ign_pass", 32'(pass4), 32'h1);

        // Reset while a_out is 7
        d0 = dcnt4;
        @(negedge clk);
        exp4   = 16'h0420;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        se = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (a4 === 4'd7) begin
                se = 0;
                break;
            end
        end
        chk("midrst_reached_7", 32'(se), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_out", 32'(a4), 32'h0);
        chk("midrst_busy", 32'(busy4), 32'h0);
        chk("midrst_observed", 32'(obs4), 32'h0);
        chk("midrst_mismatch", 32'(mc4), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("midrst_no_done", 32'(dcnt4 - d0), 32'h0);

        run4(16'h0420, 1'b0, dc, se);
        chk("post_done_cycle", 32'(dc), 32'd65);
        chk("post_pass", 32'(pass4), 32'h1);
        chk("post_observed", 32'(obs4), 32'h0420);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_checker.md
# minterm_sweep_checker

Sequential response checker for the 4-input combinational minterm blocks. On a start request it steps the unit under test through all 16 input codes on `a_out`, waits a programmable settle time per code, and samples the unit's single-bit output `d_in` into a 16-bit observed truth table. It then compares that table against an expected minterm mask latched at start and reports pass/fail, the mismatch count and the first failing code. It is the hardware counterpart of the simulation stimulus sweep, used for on-board self-check of the minterm logic.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles each input code is held before `d_in` is sampled. Legal range is 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a sweep. Accepted only in IDLE.
- `expected` input 16: expected truth table. Bit i is the required `d` for `a`=i. Latched on start acceptance.
- `a_out` output 4: input code driven to the unit under test.
- `d_in` input 1: unit-under-test output, same clock domain, no synchronizer.
- `busy` output 1: high from the cycle after start acceptance until `done`.
- `done` output 1: one-cycle pulse when results are valid.
- `pass` output 1: high when `observed` equals the latched expected table. Valid from `done` until the next start.
- `observed` output 16: captured truth table.
- `mismatch_count` output 5: number of differing bits, 0..16.
- `first_fail` output 4: lowest code that mismatched.
- `first_fail_valid` output 1: high when at least one mismatch occurred.

## Operation
- The FSM has three states: IDLE, SETTLE, DONE.
- IDLE → SETTLE when `start`=1. On that edge:
  - `a_out` is set to 0, the settle counter is loaded with SETTLE_CYCLES-1, `expected` is latched.
  - `observed`, `mismatch_count`, `first_fail` and `first_fail_valid` are cleared, and `pass` is cleared.
- SETTLE, counter ≠ 0: the counter decrements.
- SETTLE, counter = 0: sample `d_in` into `observed[a_out]`.
  - If the sample differs from `expected_q[a_out]`, increment `mismatch_count`. If `first_fail_valid` is still 0, load `first_fail` with `a_out` and set `first_fail_valid`.
  - If `a_out`=15, go to DONE. Otherwise increment `a_out` and reload the counter.
- DONE → IDLE unconditionally. In DONE, `done`=1 and `pass` is set when `mismatch_count`=0 (the registered value that includes the final sample).
- `start` is ignored in SETTLE and DONE; no queuing.
- `a_out` holds 15 after the sweep until the next start.
- Results hold until the next accepted start.
- `mismatch_count` cannot wrap: it is 5 bits and the maximum is 16.

## Timing
- Reset values: state IDLE, `a_out`=0, `busy`=0, `done`=0, `pass`=0, `observed`=0, `mismatch_count`=0, `first_fail`=0, `first_fail_valid`=0.
- Start accepted at edge T0. `busy`=1 from T0 through the last SETTLE cycle.
- Code i is driven from edge T0+i·S to T0+(i+1)·S, where S=SETTLE_CYCLES. It is sampled at edge T0+(i+1)·S.
- The final sample is at T0+16·S, which enters DONE. `done`=1 for the single cycle after it, then IDLE.
- Start-to-done latency is 16·S+1 cycles: 65 with the default.
- With S=1, each code is held for one cycle and `d_in` must settle combinationally within that cycle.
- Reset assertion mid-sweep returns everything to reset values immediately. No `done` is issued.
- If `start` is high in the `done` cycle, it is ignored. A new start is accepted in IDLE only.

## Structure
- Shared package `minterm_pkg` holds:
  - `N_IN`=4 and `TT_W`=16.
  - The FSM state enum (IDLE, SETTLE, DONE).
  - The truth-table typedef `tt_t` (16-bit).
- One sub-module is natural: `settle_timer`, an 8-bit loadable down-counter with load, enable and a zero flag. Everything else is inline.

## Test plan
- Reset defaults: hold `rst_n`=0 → all outputs at reset values. Release and wait 10 cycles with no start → `busy` stays 0.
- Correct DUT: model `d`=(a==4'hA)|(a==4'h5), `expected`=16'h0420, start → `done` at T0+65, `pass`=1, `observed`=16'h0420, `mismatch_count`=0, `first_fail_valid`=0.
- Faulty DUT: same `expected`, DUT stuck at 1 → `pass`=0, `observed`=16'hFFFF, `mismatch_count`=14, `first_fail`=0, `first_fail_valid`=1.
- Sampling point: S=3, DUT output delayed 2 cycles after an `a_out` change → still passes. The same DUT with a 3-cycle delay → fails, confirming the sample is taken on the last settle cycle.
- Ignored starts: pulse `start` mid-sweep and again in the `done` cycle → exactly one `done`. `a_out` sequence 0..15 is uninterrupted.
- Reset mid-sweep: assert `rst_n`=0 while `a_out`=7 → outputs reset asynchronously, no `done`. A subsequent start completes a full sweep correctly.
